// File: rtl/size_class_allocator.sv
// Power-of-two size-class block allocator: rounds a request up to its class,
// grants the lowest free slot (optionally falling back to larger classes), and accepts frees.
module size_class_allocator #(
  parameter int SIZE_W           = 6,
  parameter int BLOCKS_PER_CLASS = 4,
  parameter bit FALLBACK         = 1'b1,
  localparam int NCLS            = SIZE_W + 1,
  localparam int CLS_W           = $clog2(NCLS),
  localparam int SLOT_W          = $clog2(BLOCKS_PER_CLASS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SIZE_W-1:0] req_size,
  output logic              rsp_valid,
  output logic              rsp_ok,
  output logic [1:0]        rsp_err,
  output logic [NCLS-1:0]   rsp_class,
  output logic [SLOT_W-1:0] rsp_slot,
  input  logic              free_valid,
  input  logic [CLS_W-1:0]  free_class,
  input  logic [SLOT_W-1:0] free_slot,
  output logic              free_err,
  output logic [NCLS-1:0]   class_full
);

  typedef enum logic [1:0] {IDLE, CLASSIFY, SEARCH, RESP} state_e;
  typedef logic [NCLS-1:0][BLOCKS_PER_CLASS-1:0] bitmap_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BADSIZE = 2'b01;
  localparam logic [1:0] ERR_FULL    = 2'b10;

  state_e                      state_q, state_d;
  logic [SIZE_W-1:0]           size_q, size_d;
  logic [CLS_W-1:0]            cur_class_q, cur_class_d;
  bitmap_t                     bitmap_q, bitmap_d;
  logic                        rsp_ok_q, rsp_ok_d;
  logic [1:0]                  rsp_err_q, rsp_err_d;
  logic [NCLS-1:0]             rsp_class_q, rsp_class_d;
  logic [SLOT_W-1:0]           rsp_slot_q, rsp_slot_d;
  logic                        free_err_q, free_err_d;

  logic [CLS_W-1:0]            size_class;
  logic [BLOCKS_PER_CLASS-1:0] cur_row;
  logic                        found, free_hit;
  logic [SLOT_W-1:0]           found_slot;
  bitmap_t                     alloc_mask, free_mask;

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == RESP);
  assign rsp_ok    = rsp_ok_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_class = rsp_class_q;
  assign rsp_slot  = rsp_slot_q;
  assign free_err  = free_err_q;

  always_comb begin
    for (int c = 0; c < NCLS; c++) class_full[c] = &bitmap_q[c];
  end

  // Smallest class whose block size covers the request; descending scan so the lowest match wins.
  always_comb begin
    size_class = '0;
    for (int c = NCLS - 1; c >= 0; c--) begin
      if (({{SIZE_W{1'b0}}, 1'b1} << c) >= {1'b0, size_q}) size_class = CLS_W'(c);
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latches).
    state_d     = state_q;
    size_d      = size_q;
    cur_class_d = cur_class_q;
    rsp_ok_d    = rsp_ok_q;
    rsp_err_d   = rsp_err_q;
    rsp_class_d = rsp_class_q;
    rsp_slot_d  = rsp_slot_q;
    alloc_mask  = '0;
    free_mask   = '0;
    free_hit    = 1'b0;
    cur_row     = '0;
    found       = 1'b0;
    found_slot  = '0;

    for (int c = 0; c < NCLS; c++) begin
      for (int s = 0; s < BLOCKS_PER_CLASS; s++) begin
        if (free_valid && free_class == CLS_W'(c) && free_slot == SLOT_W'(s) && bitmap_q[c][s]) begin
          free_mask[c][s] = 1'b1;
          free_hit        = 1'b1;
        end
      end
      if (cur_class_q == CLS_W'(c)) cur_row = bitmap_q[c];
    end
    free_err_d = free_valid && !free_hit;

    for (int s = BLOCKS_PER_CLASS - 1; s >= 0; s--) begin
      if (!cur_row[s]) begin
        found      = 1'b1;
        found_slot = SLOT_W'(s);
      end
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        if (size_q == '0) begin
          rsp_ok_d    = 1'b0;
          rsp_err_d   = ERR_BADSIZE;
          rsp_class_d = '0;
          rsp_slot_d  = '0;
          state_d     = RESP;
        end else begin
          cur_class_d = size_class;
          state_d     = SEARCH;
        end
      end
      SEARCH: begin
        if (found) begin
          for (int c = 0; c < NCLS; c++) begin
            if (cur_class_q == CLS_W'(c))
              alloc_mask[c] = {{(BLOCKS_PER_CLASS-1){1'b0}}, 1'b1} << found_slot;
          end
          rsp_ok_d    = 1'b1;
          rsp_err_d   = ERR_NONE;
          rsp_class_d = {{(NCLS-1){1'b0}}, 1'b1} << cur_class_q;
          rsp_slot_d  = found_slot;
          state_d     = RESP;
        end else if (FALLBACK && cur_class_q < CLS_W'(NCLS - 1)) begin
          cur_class_d = cur_class_q + CLS_W'(1);
        end else begin
          rsp_ok_d    = 1'b0;
          rsp_err_d   = ERR_FULL;
          rsp_class_d = '0;
          rsp_slot_d  = '0;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The search looked at the pre-edge bitmap, so a slot freed on this edge is never granted on it.
    bitmap_d = (bitmap_q & ~free_mask) | alloc_mask;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      // NOTE: the bitmap is plain flops, not a RAM, so it is reset with everything else.
      state_q     <= IDLE;
      size_q      <= '0;
      cur_class_q <= '0;
      bitmap_q    <= '0;
      rsp_ok_q    <= 1'b0;
      rsp_err_q   <= ERR_NONE;
      rsp_class_q <= '0;
      rsp_slot_q  <= '0;
      free_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      cur_class_q <= cur_class_d;
      bitmap_q    <= bitmap_d;
      rsp_ok_q    <= rsp_ok_d;
      rsp_err_q   <= rsp_err_d;
      rsp_class_q <= rsp_class_d;
      rsp_slot_q  <= rsp_slot_d;
      free_err_q  <= free_err_d;
    end
  end

endmodule

// File: doc/size_class_allocator.md
# size_class_allocator

Parametrised successor to the one-hot size-class address generator. It rounds a requested memory size up to a power-of-two size class and allocates a concrete block slot from a per-class free bitmap. It supports explicit frees, optional fallback to larger classes when a class is exhausted, and error reporting. It sits between the request front-end and the memory block array: the one-hot class plus slot index select the physical block.

## Interface
- SIZE_W, 6, width of the request size; number of classes is NCLS = SIZE_W+1 (class c holds blocks of 2^c units)
- BLOCKS_PER_CLASS, 4, slots per class; power of two, >= 2; SLOT_W = log2(BLOCKS_PER_CLASS)
- FALLBACK, 1, 1 = on a full class, try the next larger classes; 0 = fail immediately
- CLS_W = clog2(NCLS), derived, not overridable

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  allocation request
- req_ready  out  1  high only in IDLE and not in reset; request is accepted on an edge with req_valid & req_ready
- req_size  in  SIZE_W  requested size in units, sampled at acceptance
- rsp_valid  out  1  one-cycle pulse; no backpressure
- rsp_ok  out  1  1 = allocation succeeded
- rsp_err  out  2  00 none, 01 BADSIZE (size 0), 10 FULL
- rsp_class  out  NCLS  one-hot class granted; all zero when rsp_ok=0
- rsp_slot  out  SLOT_W  slot granted; zero when rsp_ok=0
- free_valid  in  1  free request, accepted in any state
- free_class  in  CLS_W  class index (binary)
- free_slot  in  SLOT_W  slot to release
- free_err  out  1  one-cycle pulse: freed slot was not allocated or class >= NCLS
- class_full  out  NCLS  bit c = all slots of class c allocated (reflects the current bitmap register)

## Operation
- Class mapping: c = smallest c with 2^c >= req_size; size 1 -> c=0; 2 -> 1; 3..4 -> 2; 33..63 -> 6.
- FSM states: IDLE, CLASSIFY, SEARCH, RESP.
  - IDLE: on acceptance, latch req_size, go to CLASSIFY.
  - CLASSIFY: size 0 -> set BADSIZE, go to RESP. Otherwise latch cur_class = c and go to SEARCH.
  - SEARCH: if bitmap[cur_class] has a clear bit, set the lowest-index clear bit, latch class and slot with ok, go to RESP.
    - Else if FALLBACK=1 and cur_class < NCLS-1: cur_class+1, stay in SEARCH.
    - Else: FULL, go to RESP.
  - RESP: rsp_* registered values valid for this one cycle, rsp_valid=1; go to IDLE.
- Free:
  - Valid free clears bitmap[free_class][free_slot] at the edge.
  - Invalid free (bit already clear, or class out of range) leaves the bitmap unchanged and pulses free_err in the next cycle.
- Simultaneous free and SEARCH allocation:
  - bitmap_next = (bitmap & ~free_mask) | alloc_mask.
  - SEARCH sees the pre-edge bitmap, so a slot freed on that edge is not granted on that edge.
- rsp_* fields hold their last values outside RESP; only rsp_valid qualifies them.

## Timing
- Reset: state IDLE; all bitmaps clear; class_full=0; rsp_valid, rsp_ok, rsp_err, rsp_class, rsp_slot, free_err all 0; req_ready=0 during reset, 1 in the first cycle after.
- Latency, with the request accepted at edge E0:
  - Direct hit: rsp_valid in the cycle after E2 (3 cycles).
  - Each fallback step adds 1 cycle.
  - BADSIZE: rsp_valid after E1 (2 cycles).
  - FULL without fallback: 3 cycles.
- Throughput: at most one request in flight; req_ready drops from acceptance until the cycle after RESP.
- Reset mid-operation drops the pending request (no rsp_valid) and clears all allocations.
- class_full updates in the cycle after the bitmap edge.

## Test plan
- Mapping (defaults): sizes 1, 5, 32, 33, 63 -> rsp_class 0000001, 0001000, 0100000, 1000000, 1000000; slot 0, rsp_ok=1, rsp_valid 3 cycles after acceptance.
- Exhaustion with fallback: four size-8 requests -> class 3, slots 0,1,2,3; class_full[3]=1; fifth size-8 request -> class 0010000, slot 0, latency 4.
- FALLBACK=0: fifth size-8 request -> rsp_ok=0, rsp_err=10, rsp_class=0; latency 3.
- Size 0 -> rsp_ok=0, rsp_err=01, latency 2; bitmaps unchanged.
- Free class 3, slot 1 after exhaustion:
  - class_full[3] falls next cycle; next size-7 request -> class 3, slot 1.
  - Freeing class 3, slot 1 again -> free_err pulse, no bitmap change.
  - Free of class 7 -> free_err.
- Reset asserted while in SEARCH -> no rsp_valid; req_ready=1 the cycle after reset deasserts; next size-8 request -> class 3, slot 0.
